// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the IFU (burst reads) and the LSU
// (single-beat reads and writes). One transaction is in flight at a time and
// the two requesters are served round-robin.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read address / read data
//   lsu_ar*/lsu_r*        LSU read address / read data (single beat)
//   lsu_aw*/lsu_w*/lsu_b* LSU write address / data / response
//   m_*                   shared AXI4 master port (m_wlast tied high)
module axi_master_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // IFU
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [7:0]            ifu_arlen,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rlast,
    // LSU
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,
    // Master
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp
);

    typedef enum logic [2:0] {
        StIdle, StIfuAr, StIfuR, StLsuAr, StLsuR, StLsuWr, StLsuB
    } state_e;

    localparam logic GrantIfu = 1'b0;
    localparam logic GrantLsu = 1'b1;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   ifu_req, lsu_req, aw_hs, w_hs;

    // Every write is a single beat.
    assign m_wlast = 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantLsu;  // IFU wins the first tie
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        ifu_req      = ifu_arvalid;
        lsu_req      = lsu_awvalid | lsu_arvalid;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;

        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rlast   = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arlen     = '0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_awaddr    = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_bready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie, grant whichever side was not served last.
                if (lsu_req && (!ifu_req || last_grant_q == GrantIfu)) begin
                    state_d = lsu_awvalid ? StLsuWr : StLsuAr;
                end else if (ifu_req) begin
                    state_d = StIfuAr;
                end
            end
            StIfuAr: begin
                m_arvalid   = ifu_arvalid;
                m_araddr    = ifu_araddr;
                m_arlen     = ifu_arlen;
                ifu_arready = m_arready;
                if (ifu_arvalid && m_arready) state_d = StIfuR;
            end
            StIfuR: begin
                ifu_rvalid = m_rvalid;
                ifu_rdata  = m_rdata;
                ifu_rresp  = m_rresp;
                ifu_rlast  = m_rlast;
                m_rready   = ifu_rready;
                if (m_rvalid && ifu_rready && m_rlast) begin
                    state_d      = StIdle;
                    last_grant_d = GrantIfu;
                end
            end
            StLsuAr: begin
                m_arvalid   = lsu_arvalid;
                m_araddr    = lsu_araddr;
                lsu_arready = m_arready;
                if (lsu_arvalid && m_arready) state_d = StLsuR;
            end
            StLsuR: begin
                // Single beat: m_rlast is not consulted.
                lsu_rvalid = m_rvalid;
                lsu_rdata  = m_rdata;
                lsu_rresp  = m_rresp;
                m_rready   = lsu_rready;
                if (m_rvalid && lsu_rready) begin
                    state_d      = StIdle;
                    last_grant_d = GrantLsu;
                end
            end
            StLsuWr: begin
                // AW and W complete independently; each done flag masks its
                // channel so no beat is issued twice.
                m_awvalid   = lsu_awvalid & ~aw_done_q;
                m_awaddr    = lsu_awaddr;
                lsu_awready = m_awready & ~aw_done_q;
                m_wvalid    = lsu_wvalid & ~w_done_q;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                lsu_wready  = m_wready & ~w_done_q;
                aw_hs       = m_awvalid & m_awready;
                w_hs        = m_wvalid & m_wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = StLsuB;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            StLsuB: begin
                lsu_bvalid = m_bvalid;
                lsu_bresp  = m_bresp;
                m_bready   = lsu_bready;
                if (m_bvalid && lsu_bready) begin
                    state_d      = StIdle;
                    last_grant_d = GrantLsu;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
